// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Types and constants shared by the fetch unit and CONTROL.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int          c_XLEN       = 32;
    localparam logic [31:0] c_NOP_WORD   = 32'h0000_0013;
    localparam logic        c_PC_SRC_SEQ = 1'b0;
    localparam logic        c_PC_SRC_TGT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_gen
// Description : Combinational next-PC select and word-alignment check.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_gen
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              i_first,
    input  logic [c_XLEN-1:0] i_pc,
    input  logic              i_pc_src,
    input  logic [c_XLEN-1:0] i_pc_target,
    output logic [c_XLEN-1:0] o_next_pc,
    output logic              o_misaligned
);

    logic [c_XLEN-1:0] w_next_pc;

    // The very first fetch always goes to the reset vector, whatever CONTROL asks.
    always_comb begin
        w_next_pc = i_pc_target;
        if (i_first) begin
            w_next_pc = RESET_PC;
        end else if (i_pc_src == c_PC_SRC_SEQ) begin
            w_next_pc = i_pc + 32'd4;
        end
    end

    assign o_next_pc    = w_next_pc;
    assign o_misaligned = |w_next_pc[1:0];

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Multi-cycle instruction fetch engine (IDLE/REQ/WAIT) with timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 8,
    parameter logic [31:0] NOP_WORD = cpu_pkg::c_NOP_WORD
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        fetch_req,
    input  logic        pc_src,
    input  logic [31:0] pc_target,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc_out,
    output logic        busy,
    output logic        fetch_err,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT - 1);

    fetch_state_t r_state, w_state_d;
    logic [31:0]  r_pc, w_pc_d, r_instr, w_instr_d, r_pending, w_pending_d;
    logic [31:0]  r_mem_addr, w_mem_addr_d;
    logic [7:0]   r_cnt, w_cnt_d;
    logic         r_first, w_first_d, r_valid, w_valid_d, r_err, w_err_d;
    logic         r_mem_req, w_mem_req_d, r_busy, w_busy_d;
    logic [31:0]  w_next_pc;
    logic         w_misaligned;

    fetch_pc_gen #(
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .i_first      (r_first),
        .i_pc         (r_pc),
        .i_pc_src     (pc_src),
        .i_pc_target  (pc_target),
        .o_next_pc    (w_next_pc),
        .o_misaligned (w_misaligned)
    );

    always_comb begin
        w_state_d    = r_state;
        w_pc_d       = r_pc;
        w_instr_d    = r_instr;
        w_pending_d  = r_pending;
        w_first_d    = r_first;
        w_cnt_d      = r_cnt;
        w_mem_addr_d = r_mem_addr;
        w_valid_d    = 1'b0;
        w_err_d      = 1'b0;
        w_mem_req_d  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (fetch_req) begin
                    if (w_misaligned) begin
                        w_err_d = 1'b1;
                    end else begin
                        w_pending_d  = w_next_pc;
                        w_first_d    = 1'b0;
                        w_mem_req_d  = 1'b1;
                        w_mem_addr_d = w_next_pc;
                        w_state_d    = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                w_cnt_d   = 8'd0;
                w_state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Data arriving on the expiry cycle still counts as a hit.
                if (mem_rvalid) begin
                    w_instr_d = mem_rdata;
                    w_pc_d    = r_pending;
                    w_valid_d = 1'b1;
                    w_state_d = ST_IDLE;
                end else if (r_cnt == c_TMO_LAST) begin
                    w_err_d   = 1'b1;
                    w_state_d = ST_IDLE;
                end else begin
                    w_cnt_d = r_cnt + 8'd1;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
        w_busy_d = (w_state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC;
            r_instr    <= NOP_WORD;
            r_pending  <= RESET_PC;
            r_first    <= 1'b1;
            r_cnt      <= 8'd0;
            r_mem_addr <= 32'd0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_mem_req  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_pc       <= w_pc_d;
            r_instr    <= w_instr_d;
            r_pending  <= w_pending_d;
            r_first    <= w_first_d;
            r_cnt      <= w_cnt_d;
            r_mem_addr <= w_mem_addr_d;
            r_valid    <= w_valid_d;
            r_err      <= w_err_d;
            r_mem_req  <= w_mem_req_d;
            r_busy     <= w_busy_d;
        end
    end

    assign instr       = r_instr;
    assign instr_valid = r_valid;
    assign pc_out      = r_pc;
    assign busy        = r_busy;
    assign fetch_err   = r_err;
    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Multi-cycle instruction fetch engine feeding the lab4 control FSM. It is the supplier end of the control unit's instruction input `I`: it owns the PC, issues one request per fetch to instruction memory, and returns the instruction word with a valid strobe. It applies the control unit's PC_source select (PC+4 vs. target) when advancing. It sits between CONTROL and the instruction memory model.

Parameters:
RESET_PC, 32'h0000_0000, address of the first fetch after reset
TIMEOUT, 8, max WAIT cycles before declaring a fetch error (range 1..255)
NOP_WORD, 32'h0000_0013, value of instr after reset (addi x0,x0,0)

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  asynchronous active-low reset
fetch_req  input  1  controller requests the next instruction (single-cycle pulse, IF state)
pc_src  input  1  0 = next PC is PC+4; 1 = next PC is pc_target
pc_target  input  32  branch/jump target, sampled with fetch_req
instr  output  32  last fetched instruction word, held stable until the next successful fetch
instr_valid  output  1  one-cycle pulse when instr is updated
pc_out  output  32  address of the word currently in instr
busy  output  1  high in REQ and WAIT
fetch_err  output  1  one-cycle pulse on misaligned target or timeout
mem_req  output  1  one-cycle request strobe to instruction memory
mem_addr  output  32  request address, valid while mem_req=1
mem_rvalid  input  1  memory read data valid
mem_rdata  input  32  memory read data

Behaviour:
- Reset (async, rstn=0):
  - State=IDLE; pc_out=RESET_PC; instr=NOP_WORD; first flag=1.
  - instr_valid, busy, fetch_err, mem_req=0; mem_addr=0; wait counter=0.
  - Reset mid-fetch abandons the transaction; a later mem_rvalid for it is ignored because the FSM is in IDLE.
- FSM states: IDLE, REQ, WAIT. All outputs are registered.
- IDLE, on fetch_req=1, compute next address:
  - first=1: next = RESET_PC, and pc_src is ignored.
  - else pc_src=0: next = pc_out+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
  - else: next = pc_target.
  - If next[1:0] != 0: pulse fetch_err next cycle, stay IDLE, pc_out/instr/first unchanged.
  - Otherwise: latch next as the pending address, clear first, go to REQ.
- REQ: mem_req=1 and mem_addr=pending for exactly one cycle; go to WAIT; clear counter.
- WAIT, each cycle:
  - mem_rvalid=1: capture mem_rdata into instr and pending into pc_out; pulse instr_valid next cycle; go to IDLE.
  - Else if counter == TIMEOUT-1: pulse fetch_err next cycle; instr/pc_out unchanged; first unchanged; go to IDLE.
  - Else: increment counter.
- Latency:
  - fetch_req at cycle N -> mem_req at N+1.
  - Earliest mem_rvalid at N+2 -> instr_valid at N+3.
  - Back-to-back: fetch_req may be asserted in the same cycle instr_valid is high.
- fetch_req while busy=1 is ignored (not queued).
- mem_rvalid in IDLE or REQ is ignored.
- mem_rvalid in the cycle the counter expires counts as success; data wins over timeout.
- fetch_err and instr_valid are never high in the same cycle.
- busy = (state != IDLE).

Decomposition:
- Shared package `cpu_pkg`:
  - fetch state enum (IDLE/REQ/WAIT), NOP_WORD constant, XLEN=32.
  - PC_SRC_SEQ=1'b0, PC_SRC_TGT=1'b1 encodings shared with CONTROL.
- One natural sub-module: `fetch_pc_gen`, a combinational next-PC/alignment checker (inputs: first, pc_out, pc_src, pc_target; outputs: next, misaligned). The FSM and registers stay in the top.

Test Plan:
- First fetch after reset: release rstn, pulse fetch_req with pc_src=1, pc_target=32'h100. Memory answers 1 cycle after mem_req with 32'h00500093. Required: mem_addr=0 (target ignored), instr_valid at N+3, instr=32'h00500093, pc_out=0.
- Sequential advance: after fetching at 32'h8, pulse fetch_req with pc_src=0 -> mem_addr=32'hC. Wrap case: at pc_out=32'hFFFF_FFFC, same stimulus -> mem_addr=0.
- Branch: pc_src=1, pc_target=32'h40 -> mem_addr=32'h40, pc_out=32'h40 after instr_valid. pc_target=32'h42 -> fetch_err pulse, no mem_req, pc_out and instr unchanged.
- Timeout: TIMEOUT=8, memory never responds -> fetch_err exactly 8 cycles after WAIT entry, busy falls, instr still the previous word. Repeat with rvalid on the 8th WAIT cycle -> instr_valid, no fetch_err.
- Ignored stimuli: fetch_req pulses during WAIT, and stray mem_rvalid in IDLE with rdata=32'hDEADBEEF -> exactly one mem_req per accepted fetch, instr never equals 32'hDEADBEEF.
- Reset mid-fetch: assert rstn=0 in WAIT, then deliver mem_rvalid after release -> instr=32'h00000013, pc_out=RESET_PC, no instr_valid. The next fetch_req fetches RESET_PC.
